// File: rtl/ysyx_icache_pkg.sv
// Shared types and derived-width helpers for the ysyx_icache slice.
package ysyx_icache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_SETS       = 16;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_words, input int sets);
    return addr_w - offset_w(line_words) - index_w(sets);
  endfunction

endpackage

// File: rtl/ysyx_icache_if.sv
// Fetch-side and refill-side signals of the instruction cache, bundled per direction.
interface ysyx_icache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Both sides use level-held requests: a requester raises *arvalid with a stable
  // address and holds it until the matching *rvalid pulse; rvalid is one cycle wide.
  logic [ADDR_W-1:0] ifu_araddr;
  logic              ifu_arvalid;
  logic [DATA_W-1:0] ifu_rdata_o;
  logic              ifu_rvalid_o;
  logic              fence_i;
  logic [ADDR_W-1:0] bus_araddr_o;
  logic              bus_arvalid_o;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rvalid;

  modport slave (
    input  ifu_araddr, ifu_arvalid, fence_i, bus_rdata, bus_rvalid,
    output ifu_rdata_o, ifu_rvalid_o, bus_araddr_o, bus_arvalid_o
  );

  modport master (
    output ifu_araddr, ifu_arvalid, fence_i, bus_rdata, bus_rvalid,
    input  ifu_rdata_o, ifu_rvalid_o, bus_araddr_o, bus_arvalid_o
  );
endinterface

// File: rtl/ysyx_icache_array.sv
// Valid/tag/data storage: combinational read, one beat write port, invalidate-all.
module ysyx_icache_array #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int INDEX_W    = 4,
  parameter int TAG_W      = 24,
  parameter int CNT_W      = 2,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inv_all,
  input  logic              i_we,
  input  logic              i_last,
  input  logic [INDEX_W-1:0] i_widx,
  input  logic [CNT_W-1:0]  i_wword,
  input  logic [TAG_W-1:0]  i_wtag,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [INDEX_W-1:0] i_ridx,
  input  logic [CNT_W-1:0]  i_rword,
  output logic              o_valid,
  output logic [TAG_W-1:0]  o_tag,
  output logic [DATA_W-1:0] o_rdata
);
  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [DATA_W-1:0] r_data [SETS][LINE_WORDS];

  // Every beat but the last keeps the set invalid, so a half-written line never hits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_inv_all) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= i_last;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_data[i_widx][i_wword] <= i_wdata;
      if (i_last) r_tag[i_widx] <= i_wtag;
    end
  end

  assign o_valid = r_valid[i_ridx];
  assign o_tag   = r_tag[i_ridx];
  assign o_rdata = r_data[i_ridx][i_rword];
endmodule

// File: rtl/ysyx_icache.sv
// Direct-mapped read-only instruction cache with word-by-word line refill and fence.i.
// Define ysyx_ICACHE_PERF_EN to add saturating hit/miss counters (perf_hit_o/perf_miss_o).
module ysyx_icache
  import ysyx_icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int SETS       = DEF_SETS
) (
  input  logic          clk,
  input  logic          rst,
  ysyx_icache_if.slave  io,
  output icache_state_t dbg_state_o
`ifdef ysyx_ICACHE_PERF_EN
  ,
  output logic [31:0]   perf_hit_o,
  output logic [31:0]   perf_miss_o
`endif
);
  localparam int OFFSET_W = offset_w(LINE_WORDS);
  localparam int INDEX_W  = index_w(SETS);
  localparam int TAG_W    = tag_w(ADDR_W, LINE_WORDS, SETS);
  localparam int CNT_W    = $clog2(LINE_WORDS);
  localparam int LINE_W   = ADDR_W - OFFSET_W;

  icache_state_t     r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [LINE_W-1:0] r_line;
  logic              r_arvalid;
  logic              r_fence_pend;

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [CNT_W-1:0]   w_word;
  logic               w_valid;
  logic [TAG_W-1:0]   w_tag_rd;
  logic [DATA_W-1:0]  w_rdata;
  logic               w_idle, w_hit, w_miss, w_inv, w_beat, w_last;
  logic               w_unused_lsb;

  assign w_idx        = io.ifu_araddr[OFFSET_W +: INDEX_W];
  assign w_tag        = io.ifu_araddr[OFFSET_W+INDEX_W +: TAG_W];
  assign w_word       = io.ifu_araddr[2 +: CNT_W];
  assign w_unused_lsb = ^io.ifu_araddr[1:0];

  // A pending or arriving fence beats any lookup in the same cycle.
  assign w_idle = (r_state == IDLE);
  assign w_inv  = w_idle & (io.fence_i | r_fence_pend);
  assign w_hit  = w_idle & io.ifu_arvalid & w_valid & (w_tag_rd == w_tag) & ~w_inv;
  assign w_miss = w_idle & io.ifu_arvalid & ~w_hit & ~w_inv;
  assign w_beat = (r_state == REFILL) & r_arvalid & io.bus_rvalid;
  assign w_last = w_beat & (r_cnt == CNT_W'(LINE_WORDS - 1));

  ysyx_icache_array #(
    .SETS(SETS), .LINE_WORDS(LINE_WORDS), .INDEX_W(INDEX_W),
    .TAG_W(TAG_W), .CNT_W(CNT_W), .DATA_W(DATA_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_inv_all (w_inv),
    .i_we      (w_beat),
    .i_last    (w_last),
    .i_widx    (r_line[0 +: INDEX_W]),
    .i_wword   (r_cnt),
    .i_wtag    (r_line[INDEX_W +: TAG_W]),
    .i_wdata   (io.bus_rdata),
    .i_ridx    (w_idx),
    .i_rword   (w_word),
    .o_valid   (w_valid),
    .o_tag     (w_tag_rd),
    .o_rdata   (w_rdata)
  );

  // Request drops for the cycle after each beat, handing the arbiter back to its other port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_line       <= '0;
      r_arvalid    <= 1'b0;
      r_fence_pend <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_inv) begin
            r_fence_pend <= 1'b0;
          end else if (w_miss) begin
            r_line    <= io.ifu_araddr[ADDR_W-1:OFFSET_W];
            r_cnt     <= '0;
            r_arvalid <= 1'b1;
            r_state   <= REFILL;
          end
        end
        REFILL: begin
          if (io.fence_i) r_fence_pend <= 1'b1;
          if (w_beat) begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_arvalid <= 1'b0;
            if (w_last) r_state <= IDLE;
          end else begin
            r_arvalid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io.ifu_rvalid_o  = w_hit;
  assign io.ifu_rdata_o   = w_hit ? w_rdata : '0;
  assign io.bus_arvalid_o = r_arvalid;
  assign io.bus_araddr_o  = {r_line, r_cnt, 2'b00};
  assign dbg_state_o      = r_state;

`ifdef ysyx_ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_hit_o  <= '0;
      perf_miss_o <= '0;
    end else begin
      if (w_hit && perf_hit_o != '1)   perf_hit_o  <= perf_hit_o + 32'd1;
      if (w_miss && perf_miss_o != '1) perf_miss_o <= perf_miss_o + 32'd1;
    end
  end
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst && io.fence_i) $display("ysyx_icache perf: hit=%0d miss=%0d", perf_hit_o, perf_miss_o);
  end
`endif
`endif
endmodule

// File: tb/tb_ysyx_icache.sv
// Bench for ysyx_icache: latency-randomized bus responder, tag/valid reference model, scoreboard.
module tb_ysyx_icache;
  import ysyx_icache_pkg::*;

  localparam int SETS   = DEF_SETS;
  localparam int LW     = DEF_LINE_WORDS;
  localparam int OFF_W  = offset_w(LW);
  localparam int IDX_W  = index_w(SETS);
  localparam int BUDGET = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  icache_state_t dbg_state;
`ifdef ysyx_ICACHE_PERF_EN
  logic [31:0]   perf_hit, perf_miss;
`endif

  ysyx_icache_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  ysyx_icache dut (
    .clk         (clk),
    .rst         (rst),
    .io          (bus_if),
    .dbg_state_o (dbg_state)
`ifdef ysyx_ICACHE_PERF_EN
    ,
    .perf_hit_o  (perf_hit),
    .perf_miss_o (perf_miss)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_beats = 0;
  int          n_req = 0;
  int          n_resp = 0;
  int          bm_cnt = -1;
  int          fixed_lat = 2;
  logic [31:0] exp_q[$];
  bit          ref_valid [SETS];
  logic [31:0] ref_tag   [SETS];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Backing memory: the first line holds 0x11..0x44, everything else is a hash of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h3000000) return ({30'd0, a[3:2]} + 32'd1) * 32'h11;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> OFF_W) & (SETS - 1));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (OFF_W + IDX_W);
  endfunction

  function automatic bit ref_hit(input logic [31:0] a);
    return ref_valid[idx_of(a)] && (ref_tag[idx_of(a)] == tag_of(a));
  endfunction

  function automatic void ref_install(input logic [31:0] a);
    ref_valid[idx_of(a)] = 1'b1;
    ref_tag[idx_of(a)]   = tag_of(a);
  endfunction

  function automatic void ref_clear();
    for (int s = 0; s < SETS; s++) ref_valid[s] = 1'b0;
  endfunction

  function automatic void push_line(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'((LW * 4) - 1);
    for (int w = 0; w < LW; w++) exp_q.push_back(base + 32'(4 * w));
  endfunction

  // ---------------- bus responder (arbiter port model) ----------------
  always @(negedge clk) begin
    if (!rst) begin
      bus_if.bus_rvalid = 1'b0;
      bm_cnt = -1;
    end else if (bus_if.bus_rvalid) begin
      bus_if.bus_rvalid = 1'b0;
      bm_cnt = -1;
    end else if (bus_if.bus_arvalid_o) begin
      if (bm_cnt < 0) begin
        bm_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        n_req++;
      end
      if (bm_cnt == 0) begin
        check_val("beat_addr", bus_if.bus_araddr_o,
                  (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF);
        bus_if.bus_rdata  = mem_word(bus_if.bus_araddr_o);
        bus_if.bus_rvalid = 1'b1;
        n_beats++;
      end else begin
        bm_cnt--;
      end
    end
  end

  always @(posedge clk) begin
    if (rst && bus_if.ifu_rvalid_o) n_resp++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_fetch(input logic [31:0] addr, input bit with_fence);
    bit exp_hit;
    int b0;
    int cyc;
    @(negedge clk);
    bus_if.ifu_araddr  = addr;
    bus_if.ifu_arvalid = 1'b1;
    bus_if.fence_i     = with_fence;
    if (with_fence) begin
      #1;
      check_val("fence_blocks_resp", {31'd0, bus_if.ifu_rvalid_o}, 32'd0);
      ref_clear();
      @(negedge clk);
      bus_if.fence_i = 1'b0;
    end
    exp_hit = ref_hit(addr);
    if (!exp_hit) push_line(addr);
    b0 = n_beats;
    #1;
    cyc = 0;
    while (!bus_if.ifu_rvalid_o && cyc < BUDGET) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_val("resp_valid", {31'd0, bus_if.ifu_rvalid_o}, 32'd1);
    check_val("resp_data", bus_if.ifu_rdata_o, mem_word(addr));
    if (exp_hit) begin
      check_val("hit_latency", 32'(cyc), 32'd0);
      check_val("hit_no_bus", {31'd0, bus_if.bus_arvalid_o}, 32'd0);
    end else begin
      check_val("miss_beats", 32'(n_beats - b0), 32'(LW));
      check_val("miss_q_drained", 32'(exp_q.size()), 32'd0);
      ref_install(addr);
    end
    @(posedge clk);
    #1;
    bus_if.ifu_arvalid = 1'b0;
  endtask

  // Request dropped after the first beat (or fence raised on the second); the refill must still finish.
  task automatic do_abandon(input logic [31:0] addr, input bit with_fence);
    int b0;
    int r0;
    int cyc;
    @(negedge clk);
    bus_if.ifu_araddr  = addr;
    bus_if.ifu_arvalid = 1'b1;
    push_line(addr);
    b0 = n_beats;
    r0 = n_resp;
    cyc = 0;
    #1;
    while (n_beats < b0 + (with_fence ? 2 : 1) && cyc < BUDGET) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_val("abandon_wait", {31'd0, cyc < BUDGET}, 32'd1);
    if (with_fence) bus_if.fence_i = 1'b1;
    else bus_if.ifu_arvalid = 1'b0;
    @(negedge clk);
    bus_if.fence_i = 1'b0;
    cyc = 0;
    while (!(n_beats >= b0 + LW && dbg_state == IDLE) && cyc < BUDGET) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    bus_if.ifu_arvalid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("abandon_beats", 32'(n_beats - b0), 32'(LW));
    check_val("abandon_q_drained", 32'(exp_q.size()), 32'd0);
    if (with_fence) ref_clear();
    else begin
      check_val("abandon_no_resp", 32'(n_resp - r0), 32'd0);
      ref_install(addr);
    end
  endtask

  task automatic pulse_fence();
    @(negedge clk);
    bus_if.fence_i = 1'b1;
    @(negedge clk);
    bus_if.fence_i = 1'b0;
    ref_clear();
  endtask

  task automatic stray_rvalid();
    @(negedge clk);
    #1;
    bus_if.bus_rdata  = 32'hBADC0DE5;
    bus_if.bus_rvalid = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r0;
    int b0;
    int cyc;
    logic [31:0] a;
    bus_if.ifu_araddr  = '0;
    bus_if.ifu_arvalid = 1'b0;
    bus_if.fence_i     = 1'b0;
    bus_if.bus_rdata   = '0;
    bus_if.bus_rvalid  = 1'b0;
    ref_clear();

    repeat (2) @(negedge clk);
    check_val("rst_rvalid", {31'd0, bus_if.ifu_rvalid_o}, 32'd0);
    check_val("rst_rdata", bus_if.ifu_rdata_o, 32'd0);
    check_val("rst_arvalid", {31'd0, bus_if.bus_arvalid_o}, 32'd0);
    check_val("rst_araddr", bus_if.bus_araddr_o, 32'd0);
    check_val("rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
    #3 rst = 1'b1;

    // Cold miss then hit, 2-cycle beat latency.
    fixed_lat = 2;
    r0 = n_req;
    do_fetch(32'h30000008, 1'b0);
    check_val("cold_bus_reqs", 32'(n_req - r0), 32'd4);
    do_fetch(32'h3000000C, 1'b0);
`ifdef ysyx_ICACHE_PERF_EN
    check_val("perf_miss", perf_miss, 32'd1);
    check_val("perf_hit", perf_hit, 32'd2);
`endif

    // Conflict miss on set 0, then the original line re-misses.
    do_fetch(32'h30000108, 1'b0);
    do_fetch(32'h30000008, 1'b0);

    // Fence on beat 2 of a refill: line is dropped afterwards.
    fixed_lat = 1;
    do_abandon(32'h30000040, 1'b1);
    do_fetch(32'h30000040, 1'b0);

    // Abandoned request: line still installed, later fetch hits.
    do_abandon(32'h300000A4, 1'b0);
    do_fetch(32'h300000A8, 1'b0);

    // Fence and hit in the same cycle: fence wins, then re-miss.
    do_fetch(32'h300000AC, 1'b1);

    // Stray refill data while idle must not disturb a resident line.
    stray_rvalid();
    do_fetch(32'h300000A0, 1'b0);

    // Reset during beat 3: request drops without a clock edge.
    @(negedge clk);
    bus_if.ifu_araddr  = 32'h30000204;
    bus_if.ifu_arvalid = 1'b1;
    push_line(32'h30000204);
    b0 = n_beats;
    cyc = 0;
    #1;
    while (!(n_beats >= b0 + 2 && bus_if.bus_arvalid_o) && cyc < BUDGET) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_val("rst_mid_wait", {31'd0, cyc < BUDGET}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_val("rst_mid_arvalid", {31'd0, bus_if.bus_arvalid_o}, 32'd0);
    check_val("rst_mid_state", {31'd0, dbg_state}, {31'd0, IDLE});
    bus_if.ifu_arvalid = 1'b0;
    exp_q.delete();
    ref_clear();
    @(negedge clk);
    #3 rst = 1'b1;
    do_fetch(32'h30000204, 1'b0);

    // Randomized traffic over two tags x 16 sets with random latency and fences.
    fixed_lat = -1;
    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) pulse_fence();
      else if (r == 1) stray_rvalid();
      a = 32'h30000000 + ($urandom_range(0, 1) * 32'h100) + ($urandom_range(0, 63) * 32'd4);
      do_fetch(a, ($urandom_range(0, 7) == 0));
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ysyx_icache.md
Name: ysyx_icache

Overview:
- Direct-mapped, read-only instruction cache between the IFU fetch port and the bus arbiter's IFU port (ifu_araddr/ifu_arvalid in, ifu_rdata_o/ifu_rvalid_o out).
- Hits return in the same cycle. Misses refill one full line as sequential single-word reads through the arbiter's level-held request/valid handshake.
- fence.i invalidates every line.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, word width; fixed at 32.
- LINE_WORDS, 4, words per line; power of 2, at least 2.
- SETS, 16, number of lines; power of 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low (asserted when 0)
- ifu_araddr  in  ADDR_W  fetch address, word-aligned
- ifu_arvalid  in  1  fetch request; held until ifu_rvalid_o
- ifu_rdata_o  out  DATA_W  instruction word
- ifu_rvalid_o  out  1  rdata valid; one-cycle pulse per accepted fetch
- fence_i  in  1  invalidate-all request, single-cycle pulse
- bus_araddr_o  out  ADDR_W  refill word address, goes to the arbiter ifu_araddr
- bus_arvalid_o  out  1  refill request, goes to the arbiter ifu_arvalid
- bus_rdata  in  DATA_W  refill data, from the arbiter ifu_rdata_o
- bus_rvalid  in  1  refill beat valid, from the arbiter ifu_rvalid_o

Behaviour:
- Address split:
  - OFFSET_W = log2(LINE_WORDS) + 2
  - INDEX_W = log2(SETS)
  - TAG_W = ADDR_W - OFFSET_W - INDEX_W
  - word select = addr[OFFSET_W-1:2]
- Storage: register arrays valid[SETS], tag[SETS], data[SETS][LINE_WORDS]; reads are combinational.
- Reset (rst = 0): all valid bits cleared, state = IDLE, refill counter = 0, fence_pend = 0. ifu_rvalid_o = 0, bus_arvalid_o = 0, bus_araddr_o = 0, ifu_rdata_o = 0.
- State machine:
  - IDLE:
    - hit = ifu_arvalid & valid[idx] & tag match & !fence_pend & !fence_i.
    - On hit, ifu_rvalid_o = 1 and ifu_rdata_o = data[idx][word] in the same cycle; stay in IDLE.
    - On ifu_arvalid & !hit & !fence_i: latch the line base (addr with offset bits cleared), cnt = 0, go to REFILL. Response latency is 0 on a hit.
    - On fence_i: clear all valid bits at the next edge; no response that cycle.
  - REFILL:
    - bus_arvalid_o = 1, bus_araddr_o = base + 4*cnt.
    - On bus_rvalid: data[idx][cnt] <= bus_rdata, cnt++.
    - On bus_rvalid with cnt == LINE_WORDS-1: tag/valid written, go to IDLE.
    - bus_arvalid_o drops for one cycle between beats (registered cnt update), which gives the arbiter its return to if_a.
    - ifu_rvalid_o = 0 throughout.
  - IDLE after a refill: the held request now hits. Miss latency = sum of beat latencies + LINE_WORDS + 1 cycles.
- Boundary conditions:
  - ifu_arvalid drops mid-refill: the refill completes; the line is installed.
  - ifu_araddr changes mid-refill: ignored until IDLE.
  - fence_i during REFILL: set fence_pend. The refill finishes, then all valids are cleared, including the new line. fence_pend clears; one extra IDLE cycle with no hit.
  - fence_i and a hit in the same cycle: the fence wins; no response; the request re-misses afterwards.
  - Counter wrap: cnt is log2(LINE_WORDS) bits; the final beat wraps it to 0.
  - Conflict miss: refill overwrites the set; valid stays 0 until the last beat.
  - Reset mid-refill: bus_arvalid_o deasserts asynchronously; a partial line is never marked valid.
  - bus_rvalid outside REFILL: ignored.

Optional Feature:
- Macro: ysyx_ICACHE_PERF_EN.
- Defined:
  - Adds outputs perf_hit_o[31:0] and perf_miss_o[31:0], reset to 0.
  - perf_hit_o increments per hit response.
  - perf_miss_o increments per IDLE-to-REFILL transition.
  - Both saturate at 32'hFFFFFFFF.
  - A simulation-only $display of both counts fires on each fence_i.
- Undefined: the ports, counters and display are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ysyx_icache_pkg:
  - icache_state_t enum {IDLE, REFILL}.
  - Derived-width helper functions (OFFSET_W, INDEX_W, TAG_W).
  - Default LINE_WORDS/SETS constants.
- Natural sub-module: ysyx_icache_array (valid/tag/data storage, combinational read, single write port, invalidate-all). The FSM stays in the top.

Test Plan:
- Cold miss then hit: rst release, fetch 0x30000008; bus returns 0x11, 0x22, 0x33, 0x44 for 0x30000000..0x3000000C with 2-cycle latency each. Expect exactly 4 bus requests, then ifu_rvalid_o with 0x33. Fetch 0x3000000C then hits with 0x44 in 0 cycles and no bus_arvalid_o.
- Conflict: after the line above, fetch 0x30000108 (same index 0, new tag when SETS=16). Expect a refill, then a re-fetch of 0x30000008 misses again.
- fence_i mid-refill: pulse fence_i on beat 2 of a refill at 0x30000040. Refill completes; the next fetch of 0x30000040 misses again (4 new beats).
- Abandoned request: drop ifu_arvalid after beat 1. Remaining beats are still fetched, no ifu_rvalid_o occurs, and a later fetch of that line hits immediately.
- Reset mid-refill: assert rst during beat 3. bus_arvalid_o goes to 0 without a clock edge; after release the same fetch misses with a full 4-beat refill.
- Perf (ysyx_ICACHE_PERF_EN defined): run the first scenario. Expect perf_miss_o = 1 and perf_hit_o = 2 (held-request hit plus 0x3000000C hit).
